// File: rtl/html_layout_engine.sv
// html_layout_engine: nesting-aware HTML layout core issuing rect/glyph draw commands
module html_layout_engine #(
    parameter int X_W       = 9,
    parameter int Y_W       = 8,
    parameter int COLOR_W   = 3,
    parameter int VAL_W     = 8,
    parameter int DEPTH     = 8,
    parameter int SCREEN_W  = 320,
    parameter int SCREEN_H  = 240,
    parameter int FONT_W    = 8,
    parameter int FONT_H    = 8,
    parameter int FONT_KERN = 1,
    parameter int TAG_W     = 3,
    parameter int ATT_W     = 4,
    parameter int CHAR_W    = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic [2:0]                   ev_kind,
    input  logic [TAG_W-1:0]             ev_tag,
    input  logic [ATT_W-1:0]             ev_att_type,
    input  logic [VAL_W-1:0]             ev_att_val,
    input  logic [CHAR_W-1:0]            ev_char,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic                         cmd_kind,
    output logic [X_W-1:0]               cmd_x,
    output logic [Y_W-1:0]               cmd_y,
    output logic [X_W-1:0]               cmd_w,
    output logic [Y_W-1:0]               cmd_h,
    output logic [COLOR_W-1:0]           cmd_color,
    output logic                         cmd_border,
    output logic [COLOR_W-1:0]           cmd_border_color,
    output logic [CHAR_W-1:0]            cmd_char,
    output logic [VAL_W-1:0]             cmd_size,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         err_overflow,
    output logic                         err_underflow,
    output logic                         err_mismatch
);
    localparam int LW   = $clog2(DEPTH + 1);
    localparam int IW   = $clog2(DEPTH);
    localparam int AW   = X_W + VAL_W;
    localparam int SK_W = 8;
    localparam logic [TAG_W-1:0] TAG_BODY = TAG_W'(1), TAG_DIV = TAG_W'(2), TAG_P = TAG_W'(3);
    localparam logic [ATT_W-1:0] A_COLOR = ATT_W'(0), A_SIZE = ATT_W'(1), A_WIDTH = ATT_W'(2),
                                 A_HEIGHT = ATT_W'(3), A_BG = ATT_W'(4), A_BORDER = ATT_W'(5),
                                 A_PAD = ATT_W'(6), A_MARGIN = ATT_W'(7);
    localparam logic [2:0] K_OPEN = 3'd0, K_ATTR = 3'd1, K_END = 3'd2, K_CLOSE = 3'd3, K_CHAR = 3'd4;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [COLOR_W-1:0] color;
        logic [VAL_W-1:0]   size;
        logic [VAL_W-1:0]   pad;
        logic [VAL_W-1:0]   margin;
        logic [COLOR_W-1:0] bg;
        logic               bd;
        logic [COLOR_W-1:0] bdc;
        logic [X_W-1:0]     w;
        logic [Y_W-1:0]     h;
        logic [X_W-1:0]     ox;
        logic [Y_W-1:0]     oy;
    } lvl_t;

    typedef struct packed {
        logic               kind;
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [X_W-1:0]     w;
        logic [Y_W-1:0]     h;
        logic [COLOR_W-1:0] color;
        logic               border;
        logic [COLOR_W-1:0] border_color;
        logic [CHAR_W-1:0]  chr;
        logic [VAL_W-1:0]   size;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, APPLY, EMIT} state_t;

    state_t             state_q, state_d;
    lvl_t               stk_q [DEPTH];
    lvl_t               stk_d [DEPTH];
    lvl_t               top, par, dflt, nl, ta;
    cmd_t               cmd_q, cmd_d;
    logic [2:0]         kind_q, kind_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [ATT_W-1:0]   att_q, att_d;
    logic [VAL_W-1:0]   val_q, val_d;
    logic [CHAR_W-1:0]  chr_q, chr_d;
    logic [LW-1:0]      depth_q, depth_d;
    logic [SK_W-1:0]    skip_q, skip_d;
    logic [X_W-1:0]     cx_q, cx_d, wp, nx;
    logic [Y_W-1:0]     cy_q, cy_d;
    logic               ovf_q, ovf_d, unf_q, unf_d, mis_q, mis_d;
    logic [AW-1:0]      le, gw, gh, ny, dy;
    logic               wrap, drop;

    function automatic logic [X_W-1:0] sx(input logic [AW-1:0] v);
        return |v[AW-1:X_W] ? '1 : v[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] sy(input logic [AW-1:0] v);
        return |v[AW-1:Y_W] ? '1 : v[Y_W-1:0];
    endfunction

    // Depth 0 behaves like an implicit full-screen level with colour 0 and size 1
    always_comb begin
        dflt      = '0;
        dflt.size = VAL_W'(1);
        dflt.w    = X_W'(SCREEN_W);
        dflt.h    = Y_W'(SCREEN_H);
        top  = depth_q == '0 ? dflt : stk_q[IW'(depth_q - LW'(1))];
        par  = depth_q < LW'(2) ? dflt : stk_q[IW'(depth_q - LW'(2))];
        wp   = top.w != '0 ? top.w : (AW'(SCREEN_W) > AW'(top.ox) ? sx(AW'(SCREEN_W) - AW'(top.ox)) : '0);
        le   = AW'(top.ox) + AW'(wp) > AW'(top.pad) ? AW'(top.ox) + AW'(wp) - AW'(top.pad) : '0;
        gw   = AW'(top.size) * AW'(FONT_W);
        gh   = AW'(top.size) * AW'(FONT_H);
        wrap = AW'(cx_q) + gw > le;
        nx   = wrap ? sx(AW'(top.ox) + AW'(top.pad)) : cx_q;
        ny   = AW'(cy_q) + (wrap ? gh : '0);
        drop = ny + gh > AW'(SCREEN_H);
        dy   = (AW'(cy_q) > AW'(top.oy) + AW'(top.h) ? AW'(cy_q) : AW'(top.oy) + AW'(top.h)) + AW'(top.margin);
        nl       = '0;
        nl.tag   = tag_q;
        nl.color = top.color;
        nl.size  = top.size;
        nl.ox    = tag_q == TAG_BODY ? '0 : sx(AW'(top.ox) + AW'(top.pad));
        nl.oy    = tag_q == TAG_BODY ? '0 : cy_q;
        nl.w     = tag_q == TAG_BODY ? X_W'(SCREEN_W) : '0;
        nl.h     = tag_q == TAG_BODY ? Y_W'(SCREEN_H) : '0;
        ta        = top;
        ta.color  = att_q == A_COLOR ? val_q[COLOR_W-1:0] : top.color;
        ta.size   = att_q == A_SIZE ? (val_q == '0 ? VAL_W'(1) : val_q) : top.size;
        ta.w      = att_q == A_WIDTH ? X_W'(val_q) : top.w;
        ta.h      = att_q == A_HEIGHT ? Y_W'(val_q) : top.h;
        ta.bg     = att_q == A_BG ? val_q[COLOR_W-1:0] : top.bg;
        ta.bd     = top.bd | (att_q == A_BORDER);
        ta.bdc    = att_q == A_BORDER ? val_q[COLOR_W-1:0] : top.bdc;
        ta.pad    = att_q == A_PAD ? val_q : top.pad;
        ta.margin = att_q == A_MARGIN ? val_q : top.margin;
        ta.ox     = att_q == A_MARGIN ? sx(AW'(top.ox) + AW'(val_q)) : top.ox;
        ta.oy     = att_q == A_MARGIN ? sy(AW'(top.oy) + AW'(val_q)) : top.oy;
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        tag_d   = tag_q;
        att_d   = att_q;
        val_d   = val_q;
        chr_d   = chr_q;
        stk_d   = stk_q;
        depth_d = depth_q;
        skip_d  = skip_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        cmd_d   = cmd_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        mis_d   = mis_q;
        case (state_q)
            IDLE: if (ev_valid) begin
                kind_d  = ev_kind;
                tag_d   = ev_tag;
                att_d   = ev_att_type;
                val_d   = ev_att_val;
                chr_d   = ev_char;
                state_d = APPLY;
            end
            APPLY: begin
                state_d = IDLE;
                case (kind_q)
                    K_OPEN: if (depth_q == LW'(DEPTH)) begin
                        ovf_d  = 1'b1;
                        skip_d = skip_q + SK_W'(skip_q != '1);
                    end else begin
                        stk_d[IW'(depth_q)] = nl;
                        depth_d = depth_q + LW'(1);
                    end
                    K_ATTR: if (depth_q != '0 && skip_q == '0) stk_d[IW'(depth_q - LW'(1))] = ta;
                    K_END: if (skip_q == '0) begin
                        if (top.tag == TAG_BODY || top.tag == TAG_DIV) begin
                            cmd_d = '{kind: 1'b0, x: top.ox, y: top.oy, w: wp, h: top.h, color: top.bg,
                                      border: top.bd, border_color: top.bdc, chr: '0, size: '0};
                            state_d = EMIT;
                            cx_d = sx(AW'(top.ox) + AW'(top.pad));
                            cy_d = sy(AW'(top.oy) + AW'(top.pad));
                        end else if (top.tag == TAG_P) begin
                            cx_d = sx(AW'(top.ox) + AW'(top.pad));
                            cy_d = sy(AW'(cy_q) + AW'(top.margin));
                        end
                    end
                    K_CHAR: begin
                        cx_d = nx;
                        cy_d = sy(ny);
                        if (!drop) begin
                            cmd_d = '{kind: 1'b1, x: nx, y: sy(ny), w: '0, h: '0, color: top.color,
                                      border: 1'b0, border_color: '0, chr: chr_q, size: top.size};
                            state_d = EMIT;
                        end
                    end
                    K_CLOSE: if (skip_q != '0) skip_d = skip_q - SK_W'(1);
                    else if (depth_q == '0) unf_d = 1'b1;
                    else begin
                        mis_d   = mis_q | (tag_q != top.tag);
                        depth_d = depth_q - LW'(1);
                        if (top.tag == TAG_P) begin
                            cx_d = sx(AW'(par.ox) + AW'(par.pad));
                            cy_d = sy(AW'(cy_q) + gh);
                        end else if (top.tag == TAG_DIV) begin
                            cx_d = sx(AW'(par.ox) + AW'(par.pad));
                            cy_d = sy(dy);
                        end
                    end
                    default: ;
                endcase
            end
            EMIT: if (cmd_ready) begin
                state_d = IDLE;
                if (cmd_q.kind) cx_d = sx(AW'(cx_q) + AW'(cmd_q.size) * AW'(FONT_W + FONT_KERN));
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            kind_q  <= '0;
            tag_q   <= '0;
            att_q   <= '0;
            val_q   <= '0;
            chr_q   <= '0;
            stk_q   <= '{default: '0};
            depth_q <= '0;
            skip_q  <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            cmd_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            tag_q   <= tag_d;
            att_q   <= att_d;
            val_q   <= val_d;
            chr_q   <= chr_d;
            stk_q   <= stk_d;
            depth_q <= depth_d;
            skip_q  <= skip_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            cmd_q   <= cmd_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            mis_q   <= mis_d;
        end
    end

    assign ev_ready         = state_q == IDLE && !reset;
    assign cmd_valid        = state_q == EMIT;
    assign cmd_kind         = cmd_q.kind;
    assign cmd_x            = cmd_q.x;
    assign cmd_y            = cmd_q.y;
    assign cmd_w            = cmd_q.w;
    assign cmd_h            = cmd_q.h;
    assign cmd_color        = cmd_q.color;
    assign cmd_border       = cmd_q.border;
    assign cmd_border_color = cmd_q.border_color;
    assign cmd_char         = cmd_q.chr;
    assign cmd_size         = cmd_q.size;
    assign level            = depth_q;
    assign err_overflow     = ovf_q;
    assign err_underflow    = unf_q;
    assign err_mismatch     = mis_q;
endmodule
